// File: rtl/control_unit_seq.sv
// control_unit_seq: multi-cycle control unit for the 8-bit CPU.
// Owns its FSM state, start handshake, memory wait-states/timeout, retire count.
// Ports: clk, reset (async, active-low), start, instr, zf, mem_ready in;
//        state, PC/addr/mem/ALU/regfile strobes, halt, fault, retired out.
module control_unit_seq #(
   parameter int DATA_W   = 8,
   parameter int OFFSET_W = 4,
   parameter int MAX_WAIT = 15,
   parameter int RETIRE_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [DATA_W-1:0]   instr,
   input  logic                zf,
   input  logic                mem_ready,
   output logic [2:0]          state,
   output logic                pc_we,
   output logic                pc_sel,
   output logic                pc_jmp_sel,
   output logic [OFFSET_W-1:0] pc_offset,
   output logic                addr_sel,
   output logic [OFFSET_W-1:0] addr_offset,
   output logic                mem_sel,
   output logic                mem_we,
   output logic [2:0]          alu_opcode,
   output logic                alu_sel_a,
   output logic                alu_sel_b,
   output logic                alu_we,
   output logic                zf_we,
   output logic                ir_we,
   output logic                a_sel,
   output logic                a_we,
   output logic                b_sel,
   output logic                b_we,
   output logic                halt,
   output logic                fault,
   output logic [RETIRE_W-1:0] retired
);

   localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

   typedef enum logic [2:0] {
      S_FETCH   = 3'b000,
      S_DECODE  = 3'b001,
      S_EXECUTE = 3'b010,
      S_MEMORY  = 3'b011,
      S_WB      = 3'b100,
      S_HALT    = 3'b101,
      S_IDLE    = 3'b110,
      S_ILLEGAL = 3'b111
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic                r_fault;
   logic [RETIRE_W-1:0] r_retired;
   logic [WAIT_W-1:0]   r_wait;
   logic [WAIT_W-1:0]   w_wait_next;
   logic [2:0]          w_op;
   logic [OFFSET_W-1:0] w_off;
   logic                w_timeout;
   logic                w_retire;
   logic                w_fault_set;
   logic                w_unused;

   assign w_op     = instr[DATA_W-1 -: 3];
   assign w_off    = instr[OFFSET_W-1:0];
   assign w_unused = ^instr;

   // A stalled access may sit at the limit for one more cycle; only a
   // still-low mem_ready in that cycle faults.
   assign w_timeout = (MAX_WAIT != 0) && !mem_ready &&
                      (r_wait == WAIT_W'(MAX_WAIT));

   assign state   = r_state;
   assign fault   = r_fault;
   assign retired = r_retired;

   always_comb begin
      w_next      = r_state;
      w_retire    = 1'b0;
      w_fault_set = 1'b0;
      pc_we       = 1'b0;
      pc_sel      = 1'b0;
      pc_jmp_sel  = 1'b0;
      pc_offset   = '0;
      addr_sel    = 1'b0;
      addr_offset = '0;
      mem_sel     = 1'b0;
      mem_we      = 1'b0;
      alu_opcode  = 3'b000;
      alu_sel_a   = 1'b0;
      alu_sel_b   = 1'b0;
      alu_we      = 1'b0;
      zf_we       = 1'b0;
      ir_we       = 1'b0;
      a_sel       = 1'b0;
      a_we        = 1'b0;
      b_sel       = 1'b0;
      b_we        = 1'b0;
      halt        = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start) w_next = S_FETCH;
         end
         S_FETCH: begin
            if (mem_ready) begin
               ir_we  = 1'b1;
               pc_we  = 1'b1;
               w_next = S_DECODE;
            end else if (w_timeout) begin
               w_next      = S_HALT;
               w_fault_set = 1'b1;
            end
         end
         S_DECODE: begin
            w_next = (w_op == 3'b111) ? S_HALT : S_EXECUTE;
         end
         S_EXECUTE: begin
            unique case (w_op)
               3'b000, 3'b001: begin
                  addr_sel    = 1'b1;
                  addr_offset = w_off;
                  w_next      = S_MEMORY;
               end
               3'b010, 3'b011: begin
                  alu_opcode = {2'b00, w_op[0]};
                  alu_we     = 1'b1;
                  zf_we      = 1'b1;
                  w_next     = S_WB;
               end
               3'b100, 3'b101: begin
                  if (!w_op[0] || zf) begin
                     pc_we     = 1'b1;
                     pc_sel    = 1'b1;
                     pc_offset = w_off;
                  end
                  w_next   = S_FETCH;
                  w_retire = 1'b1;
               end
               3'b110: begin
                  b_sel    = 1'b1;
                  b_we     = 1'b1;
                  w_next   = S_FETCH;
                  w_retire = 1'b1;
               end
               3'b111: begin
                  w_next = S_HALT;
               end
            endcase
         end
         S_MEMORY: begin
            addr_sel    = 1'b1;
            addr_offset = w_off;
            mem_sel     = 1'b1;
            mem_we      = (w_op != 3'b000);
            if (mem_ready) begin
               if (w_op == 3'b000) begin
                  w_next = S_WB;
               end else begin
                  w_next   = S_FETCH;
                  w_retire = 1'b1;
               end
            end else if (w_timeout) begin
               w_next      = S_HALT;
               w_fault_set = 1'b1;
            end
         end
         S_WB: begin
            a_we     = 1'b1;
            a_sel    = (w_op == 3'b000);
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end
         S_HALT: begin
            halt = 1'b1;
         end
         S_ILLEGAL: begin
            w_next      = S_HALT;
            w_fault_set = 1'b1;
         end
      endcase
   end

   // Counter only runs while stalled in an access state; any move clears it.
   always_comb begin
      w_wait_next = '0;
      if ((r_state == S_FETCH || r_state == S_MEMORY) && w_next == r_state)
         w_wait_next = r_wait + WAIT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_fault   <= 1'b0;
         r_retired <= '0;
         r_wait    <= '0;
      end else begin
         r_state <= w_next;
         r_wait  <= w_wait_next;
         if (w_fault_set) r_fault <= 1'b1;
         if (w_retire) r_retired <= r_retired + RETIRE_W'(1);
      end
   end

endmodule

// File: tb/tb_control_unit_seq.sv
// tb_control_unit_seq: directed plus randomized check of control_unit_seq
// against a cycle-level behavioural model of the instruction flow.
module tb_control_unit_seq;

   localparam int MW = 15;
   localparam int ST_FETCH = 0, ST_DEC = 1, ST_EXE = 2, ST_MEM = 3;
   localparam int ST_WB = 4, ST_HALT = 5, ST_IDLE = 6;

   logic        clk = 1'b0;
   logic        reset, start, zf, mem_ready;
   logic [7:0]  instr;
   logic [2:0]  state;
   logic        pc_we, pc_sel, pc_jmp_sel;
   logic [3:0]  pc_offset, addr_offset;
   logic        addr_sel, mem_sel, mem_we;
   logic [2:0]  alu_opcode;
   logic        alu_sel_a, alu_sel_b, alu_we, zf_we, ir_we;
   logic        a_sel, a_we, b_sel, b_we, halt, fault;
   logic [15:0] retired;

   typedef struct packed {
      logic [2:0]  st;
      logic        pc_we, pc_sel, pc_jmp_sel;
      logic [3:0]  pc_off;
      logic        addr_sel;
      logic [3:0]  addr_off;
      logic        mem_sel, mem_we;
      logic [2:0]  alu_op;
      logic        alu_sel_a, alu_sel_b, alu_we, zf_we, ir_we;
      logic        a_sel, a_we, b_sel, b_we, halt, fault;
      logic [15:0] ret;
   } outs_t;

   int          checks = 0;
   int          errors = 0;
   int          m_st = ST_IDLE;
   bit          m_fault = 1'b0;
   int unsigned m_ret = 0;
   int          m_wait = 0;

   always #5 clk = ~clk;

   control_unit_seq #(
      .DATA_W(8), .OFFSET_W(4), .MAX_WAIT(MW), .RETIRE_W(16)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .instr(instr),
      .zf(zf), .mem_ready(mem_ready), .state(state),
      .pc_we(pc_we), .pc_sel(pc_sel), .pc_jmp_sel(pc_jmp_sel),
      .pc_offset(pc_offset), .addr_sel(addr_sel),
      .addr_offset(addr_offset), .mem_sel(mem_sel), .mem_we(mem_we),
      .alu_opcode(alu_opcode), .alu_sel_a(alu_sel_a),
      .alu_sel_b(alu_sel_b), .alu_we(alu_we), .zf_we(zf_we),
      .ir_we(ir_we), .a_sel(a_sel), .a_we(a_we), .b_sel(b_sel),
      .b_we(b_we), .halt(halt), .fault(fault), .retired(retired)
   );

   function automatic outs_t dut_out();
      outs_t o;
      o.st = state; o.pc_we = pc_we; o.pc_sel = pc_sel;
      o.pc_jmp_sel = pc_jmp_sel; o.pc_off = pc_offset;
      o.addr_sel = addr_sel; o.addr_off = addr_offset;
      o.mem_sel = mem_sel; o.mem_we = mem_we; o.alu_op = alu_opcode;
      o.alu_sel_a = alu_sel_a; o.alu_sel_b = alu_sel_b;
      o.alu_we = alu_we; o.zf_we = zf_we; o.ir_we = ir_we;
      o.a_sel = a_sel; o.a_we = a_we; o.b_sel = b_sel; o.b_we = b_we;
      o.halt = halt; o.fault = fault; o.ret = retired;
      return o;
   endfunction

   // What the strobes must be, phase by phase, for the current instruction.
   function automatic outs_t model_out();
      outs_t o = '0;
      int op = int'(instr[7:5]);
      o.st    = 3'(m_st);
      o.fault = m_fault;
      o.ret   = 16'(m_ret);
      if (m_st == ST_FETCH) begin
         o.ir_we = mem_ready;
         o.pc_we = mem_ready;
      end else if (m_st == ST_EXE) begin
         if (op == 0 || op == 1) begin
            o.addr_sel = 1'b1; o.addr_off = instr[3:0];
         end else if (op == 2 || op == 3) begin
            o.alu_op = (op == 3) ? 3'd1 : 3'd0;
            o.alu_we = 1'b1; o.zf_we = 1'b1;
         end else if (op == 4 || (op == 5 && zf)) begin
            o.pc_we = 1'b1; o.pc_sel = 1'b1; o.pc_off = instr[3:0];
         end else if (op == 6) begin
            o.b_sel = 1'b1; o.b_we = 1'b1;
         end
      end else if (m_st == ST_MEM) begin
         o.addr_sel = 1'b1; o.addr_off = instr[3:0];
         o.mem_sel  = 1'b1; o.mem_we = (op == 1);
      end else if (m_st == ST_WB) begin
         o.a_we = 1'b1; o.a_sel = (op == 0);
      end else if (m_st == ST_HALT) begin
         o.halt = 1'b1;
      end
      return o;
   endfunction

   task automatic model_advance();
      int op = int'(instr[7:5]);
      case (m_st)
         ST_IDLE: if (start) begin m_st = ST_FETCH; m_wait = 0; end
         ST_FETCH, ST_MEM: begin
            if (mem_ready) begin
               if (m_st == ST_FETCH) m_st = ST_DEC;
               else if (op == 0) m_st = ST_WB;
               else begin m_st = ST_FETCH; m_ret++; end
               m_wait = 0;
            end else if (MW != 0 && m_wait == MW) begin
               m_st = ST_HALT; m_fault = 1'b1;
            end else begin
               m_wait++;
            end
         end
         ST_DEC: m_st = (op == 7) ? ST_HALT : ST_EXE;
         ST_EXE: begin
            if (op <= 1) begin m_st = ST_MEM; m_wait = 0; end
            else if (op <= 3) m_st = ST_WB;
            else begin m_st = ST_FETCH; m_ret++; m_wait = 0; end
         end
         ST_WB: begin m_st = ST_FETCH; m_ret++; m_wait = 0; end
         default: ;
      endcase
   endtask

   task automatic step();
      outs_t e, a;
      @(negedge clk);
      if (!reset) begin
         m_st = ST_IDLE; m_fault = 1'b0; m_ret = 0; m_wait = 0;
      end
      e = model_out();
      a = dut_out();
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL cycle_cmp t=%0t got %h want %h", $time, a, e);
      end
      @(posedge clk);
      if (reset) model_advance();
      #1;
   endtask

   task automatic chk(input string nm, input longint unsigned act,
                      input longint unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   initial begin
      outs_t o;
      int burst = 0;
      int hcnt  = 0;
      reset = 1'b0; start = 1'b0; instr = 8'h00;
      zf = 1'b0; mem_ready = 1'b0;
      step(); step();
      o = dut_out();
      chk("rst_state", state, 6);
      o.st = '0;
      chk("rst_outs", 64'(o), 0);

      reset = 1'b1;
      repeat (5) step();
      chk("idle_state", state, 6);
      chk("idle_ret", retired, 0);
      start = 1'b1; step(); start = 1'b0;
      chk("start_fetch", state, 0);

      // ADD
      instr = 8'b010_00011; mem_ready = 1'b1; #1;
      chk("add_fetch_irwe", {ir_we, pc_we, pc_sel}, 3'b110);
      step(); chk("add_decode", state, 1);
      step(); #1;
      chk("add_exe", {state, alu_we, zf_we, alu_opcode}, {3'd2, 2'b11, 3'd0});
      step();
      chk("add_wb", {state, a_we, a_sel}, {3'd4, 2'b10});
      step();
      chk("add_ret", {state, retired}, {3'd0, 16'd1});

      // LDA with three wait cycles in MEMORY
      instr = 8'b000_00101;
      step(); step(); step();
      chk("lda_mem", state, 3);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("lda_hold", {mem_sel, mem_we, addr_offset}, {2'b10, 4'h5});
         step();
      end
      mem_ready = 1'b1;
      #1 chk("lda_last", {state, mem_sel, addr_offset}, {3'd3, 1'b1, 4'h5});
      step();
      chk("lda_wb", {state, a_we, a_sel}, {3'd4, 2'b11});
      step();
      chk("lda_ret", {state, retired}, {3'd0, 16'd2});

      // JZ not taken then taken
      instr = 8'b101_01010; zf = 1'b0;
      step(); step(); #1;
      chk("jz0_exe", {state, pc_we}, {3'd2, 1'b0});
      step();
      chk("jz0_ret", {state, retired}, {3'd0, 16'd3});
      zf = 1'b1;
      step(); step(); #1;
      chk("jz1_exe", {pc_we, pc_sel, pc_offset}, {2'b11, 4'hA});
      step();
      chk("jz1_ret", {state, retired}, {3'd0, 16'd4});

      // 15 tolerated low cycles; mem_ready at the limit still completes
      mem_ready = 1'b0;
      repeat (MW) step();
      chk("lim_still_fetch", {state, fault}, {3'd0, 1'b0});
      mem_ready = 1'b1;
      step();
      chk("lim_complete", {state, fault}, {3'd1, 1'b0});
      step(); step();
      chk("lim_back", state, 0);

      // timeout: the 16th consecutive low cycle faults
      mem_ready = 1'b0;
      repeat (MW) step();
      chk("to_pre", state, 0);
      step();
      chk("to_halt", {state, halt, fault}, {3'd5, 2'b11});
      start = 1'b1; step(); start = 1'b0; step();
      chk("to_sticky", {state, halt, fault}, {3'd5, 2'b11});
      reset = 1'b0; #1;
      chk("to_rst", {state, halt, fault}, {3'd6, 2'b00});
      step(); reset = 1'b1;

      // HALT opcode after one retired ADD
      start = 1'b1; step(); start = 1'b0;
      instr = 8'b010_00000; mem_ready = 1'b1;
      repeat (4) step();
      instr = 8'b111_00000;
      step(); step();
      chk("hlt_op", {state, halt, fault, retired}, {3'd5, 2'b10, 16'd1});
      reset = 1'b0; step(); reset = 1'b1;

      // reset in the middle of a stalled STA
      start = 1'b1; step(); start = 1'b0;
      instr = 8'b001_00111;
      step(); step(); step();
      mem_ready = 1'b0; #1;
      chk("sta_hold", {mem_sel, mem_we, addr_offset}, {2'b11, 4'h7});
      reset = 1'b0; #1;
      chk("sta_rst", {state, mem_we, mem_sel}, {3'd6, 2'b00});
      step(); reset = 1'b1;

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         hcnt = (m_st == ST_HALT) ? hcnt + 1 : 0;
         if (!reset) reset = 1'b1;
         else if (hcnt > 3 || $urandom_range(0, 299) == 0) reset = 1'b0;
         start = ($urandom_range(0, 3) == 0);
         zf    = 1'($urandom);
         if (burst > 0) begin
            mem_ready = 1'b0; burst--;
         end else if ($urandom_range(0, 39) == 0) begin
            burst = $urandom_range(10, 18); mem_ready = 1'b0;
         end else begin
            mem_ready = ($urandom_range(0, 3) != 0);
         end
         if (m_st == ST_FETCH || m_st == ST_IDLE || m_st == ST_HALT) begin
            instr[4:0] = 5'($urandom);
            instr[7:5] = ($urandom_range(0, 19) == 0) ? 3'd7
                         : 3'($urandom_range(0, 6));
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
